// File: rtl/bnn_seq_pkg.sv
// Shared types and constants for the BNN layer sequencer: state encoding,
// width defaults, per-layer configuration record and stock layer lengths.
package bnn_seq_pkg;

   localparam int CW      = 8;
   localparam int RW      = 5;
   localparam int SW      = 6;
   localparam int GW      = 3;
   localparam int AW      = 9;
   localparam int TW      = 7;
   localparam int GSTRIDE = 48;

   typedef enum logic [2:0] {
      S_IDLE, S_PRE, S_ROW, S_LAST, S_TAIL, S_DONE
   } seq_state_e;

   typedef struct packed {
      logic [CW-1:0] pre_len;
      logic [RW-1:0] nrows;
      logic [CW-1:0] row_len;
      logic [CW-1:0] valid_len;
      logic [CW-1:0] last_len;
      logic [CW-1:0] tail_len;
   } layer_cfg_t;

   localparam layer_cfg_t CFG_CONV2 = '{pre_len: CW'(34), nrows: RW'(9), row_len: CW'(14),
                                        valid_len: CW'(12), last_len: CW'(12), tail_len: CW'(0)};
   localparam layer_cfg_t CFG_CONV3 = '{pre_len: CW'(44), nrows: RW'(6), row_len: CW'(12),
                                        valid_len: CW'(9), last_len: CW'(9), tail_len: CW'(0)};
   localparam layer_cfg_t CFG_FC    = '{pre_len: CW'(56), nrows: RW'(1), row_len: CW'(0),
                                        valid_len: CW'(0), last_len: CW'(1), tail_len: CW'(6)};

   // Phase that follows preload (or launch when preload is empty).
   function automatic seq_state_e first_phase(input logic [RW-1:0] nrows,
                                              input logic [CW-1:0] tail_len);
      if (nrows > RW'(1))       return S_ROW;
      else if (nrows == RW'(1)) return S_LAST;
      else if (tail_len != '0)  return S_TAIL;
      return S_DONE;
   endfunction

endpackage

// File: rtl/bnn_layer_seq_if.sv
// Controller <-> sequencer bundle: launch/abort, layer config, ROM indices and
// the sequencer's strobes and ROM addresses.
interface bnn_layer_seq_if;
   import bnn_seq_pkg::*;

   logic          iSTART;
   logic          iABORT;
   logic [CW-1:0] iPRE_LEN;
   logic [RW-1:0] iNROWS;
   logic [CW-1:0] iROW_LEN;
   logic [CW-1:0] iVALID_LEN;
   logic [CW-1:0] iLAST_LEN;
   logic [CW-1:0] iTAIL_LEN;
   logic [AW-1:0] iWBASE;
   logic [TW-1:0] iTBASE;
   logic [SW-1:0] iSTAGE;
   logic [GW-1:0] iGROUP;
   logic          oBUSY;
   logic          oSR_EN;
   logic [RW-1:0] oROW;
   logic          oEND;
   logic          oFINISH;
   logic [AW-1:0] oWADDR;
   logic [TW-1:0] oTADDR;

   modport master (
      output iSTART, iABORT, iPRE_LEN, iNROWS, iROW_LEN, iVALID_LEN, iLAST_LEN,
             iTAIL_LEN, iWBASE, iTBASE, iSTAGE, iGROUP,
      input  oBUSY, oSR_EN, oROW, oEND, oFINISH, oWADDR, oTADDR
   );

   modport slave (
      input  iSTART, iABORT, iPRE_LEN, iNROWS, iROW_LEN, iVALID_LEN, iLAST_LEN,
             iTAIL_LEN, iWBASE, iTBASE, iSTAGE, iGROUP,
      output oBUSY, oSR_EN, oROW, oEND, oFINISH, oWADDR, oTADDR
   );

endinterface

// File: rtl/bnn_seq_addr_gen.sv
// Registered weight/threshold ROM address arithmetic; one cycle of latency so
// the address lines up with the synchronous ROM read.
module bnn_seq_addr_gen
   import bnn_seq_pkg::*;
(
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic [AW-1:0] wbase_i,
   input  logic [TW-1:0] tbase_i,
   input  logic [SW-1:0] stage_i,
   input  logic [GW-1:0] group_i,
   output logic [AW-1:0] waddr_o,
   output logic [TW-1:0] taddr_o
);

   localparam logic [AW-1:0] GSTRIDE_W = AW'(GSTRIDE);

   logic [AW-1:0] waddr_d, waddr_q;
   logic [TW-1:0] taddr_d, taddr_q;

   // Sums are kept at address width so they wrap naturally.
   assign waddr_d = wbase_i + AW'(group_i) * GSTRIDE_W + AW'(stage_i);
   assign taddr_d = tbase_i + TW'(stage_i);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         waddr_q <= '0;
         taddr_q <= '0;
      end else begin
         waddr_q <= waddr_d;
         taddr_q <= taddr_d;
      end
   end

   assign waddr_o = waddr_q;
   assign taddr_o = taddr_q;

endmodule

// File: rtl/bnn_layer_seq.sv
// Runtime-configurable BNN layer sequencer: preload, N rows with a shortened
// last row, optional finish tail, end pulse; plus ROM address generation.
module bnn_layer_seq
   import bnn_seq_pkg::*;
(
   input  logic           iCLK,
   input  logic           iRST_N,
   bnn_layer_seq_if.slave bus
);

   seq_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [RW-1:0] row_q, row_d;
   layer_cfg_t    cfg_q, cfg_d, cfg_in;
   logic [CW-1:0] row_eff, last_eff, vld_eff;

   assign cfg_in = '{pre_len: bus.iPRE_LEN, nrows: bus.iNROWS, row_len: bus.iROW_LEN,
                     valid_len: bus.iVALID_LEN, last_len: bus.iLAST_LEN,
                     tail_len: bus.iTAIL_LEN};

   // Zero-length row/last phases still occupy one cycle.
   assign row_eff  = (cfg_q.row_len == '0) ? CW'(1) : cfg_q.row_len;
   assign last_eff = (cfg_q.last_len == '0) ? CW'(1) : cfg_q.last_len;
   assign vld_eff  = (cfg_q.valid_len < row_eff) ? cfg_q.valid_len : row_eff;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      row_d   = row_q;
      cfg_d   = cfg_q;
      unique case (state_q)
         S_IDLE: if (bus.iSTART) begin
            cfg_d   = cfg_in;
            state_d = (cfg_in.pre_len != '0) ? S_PRE
                                             : first_phase(cfg_in.nrows, cfg_in.tail_len);
         end
         S_PRE:  if (cnt_q == cfg_q.pre_len - CW'(1))
                    state_d = first_phase(cfg_q.nrows, cfg_q.tail_len);
         S_ROW:  if (cnt_q == row_eff - CW'(1)) begin
            row_d = row_q + RW'(1);
            cnt_d = '0;
            if (row_q == cfg_q.nrows - RW'(2)) state_d = S_LAST;
         end
         S_LAST: if (cnt_q == last_eff - CW'(1))
                    state_d = (cfg_q.tail_len != '0) ? S_TAIL : S_DONE;
         S_TAIL: if (cnt_q == cfg_q.tail_len - CW'(1)) state_d = S_DONE;
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Abort overrides both launch and the normal phase transition.
      if (bus.iABORT && state_q != S_IDLE) state_d = S_IDLE;
      if (state_d != state_q || state_q == S_IDLE) cnt_d = '0;
      if (state_d == S_IDLE) row_d = '0;
   end

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
         cfg_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         cfg_q   <= cfg_d;
      end
   end

   assign bus.oBUSY   = (state_q != S_IDLE);
   assign bus.oSR_EN  = (state_q == S_LAST) || (state_q == S_ROW && cnt_q < vld_eff);
   assign bus.oROW    = row_q;
   assign bus.oEND    = (state_q == S_DONE);
   assign bus.oFINISH = (state_q == S_TAIL);

   bnn_seq_addr_gen u_addr (
      .clk_i   (iCLK),
      .rst_ni  (iRST_N),
      .wbase_i (bus.iWBASE),
      .tbase_i (bus.iTBASE),
      .stage_i (bus.iSTAGE),
      .group_i (bus.iGROUP),
      .waddr_o (bus.oWADDR),
      .taddr_o (bus.oTADDR)
   );

endmodule

// File: doc/bnn_layer_seq.md
Name: bnn_layer_seq

Overview:
Generic, runtime-configurable layer sequencer for the BNN engine.
- Replaces the hard-coded per-layer conv2/conv3/fc state chains with one parametrised FSM: preload phase, N row phases, shortened last row, optional tail window, end pulse.
- Generates the shift-register enable, end/finish strobes and the weight/threshold ROM addresses for whichever layer the controller launches.
- Sits between the top-level stage controller and the BNN datapath/ROMs.

Parameters:
- CW, 8, width of phase counters and of every length config input
- RW, 5, width of row count/index
- SW, 6, width of external stage index
- GW, 3, width of external group index
- AW, 9, weight ROM address width
- TW, 7, threshold ROM address width
- GSTRIDE, 48, weight address stride per group

Ports:
- iCLK  in  1  clock
- iRST_N  in  1  asynchronous active-low reset
- iSTART  in  1  launch pulse, accepted only in IDLE
- iABORT  in  1  synchronous abort
- iPRE_LEN  in  CW  preload cycles (0 = skip)
- iNROWS  in  RW  row count including last row (0 = no rows)
- iROW_LEN  in  CW  cycles per normal row
- iVALID_LEN  in  CW  enabled cycles per normal row
- iLAST_LEN  in  CW  cycles of last row, all enabled
- iTAIL_LEN  in  CW  finish-window cycles (0 = skip)
- iWBASE  in  AW  weight base address
- iTBASE  in  TW  threshold base address
- iSTAGE  in  SW  stage index
- iGROUP  in  GW  group index
- oBUSY  out  1  high in any non-IDLE state
- oSR_EN  out  1  datapath shift enable
- oROW  out  RW  current row index
- oEND  out  1  one-cycle completion pulse
- oFINISH  out  1  high throughout TAIL
- oWADDR  out  AW  weight ROM address
- oTADDR  out  TW  threshold ROM address

Behaviour:
- Reset (iRST_N low, async): state IDLE; counters, oROW and latched config 0; all outputs 0.
- The config set is latched on the accepted iSTART. Later config changes have no effect until the next start. iSTART while oBUSY is ignored.
- States: IDLE, PRE, ROW, LAST, TAIL, DONE. Moore outputs decoded from registered state and counters.
- IDLE on iSTART: go to PRE if pre_len>0; else ROW if nrows>1; else LAST if nrows==1; else TAIL/DONE.
- PRE: cnt counts 0..pre_len-1. On the last count, take the same row/last/tail choice as above. oSR_EN=0.
- ROW: cnt counts 0..row_len-1. oSR_EN = (cnt < min(valid_len,row_len)). At cnt==row_len-1, oROW increments. Exit to LAST when oROW==nrows-2 at row end. row_len==0 is treated as 1.
- LAST: oSR_EN=1 for last_len cycles (0 treated as 1). Then go to TAIL if tail_len>0, else DONE.
- TAIL: oFINISH=1 for tail_len cycles, oSR_EN=0. Then go to DONE.
- DONE: oEND=1 for one cycle, then IDLE. A new iSTART is accepted the cycle after DONE.
- The counter clears on every state change.
- Total oSR_EN cycles = (nrows-1)*min(valid,row)+last_len.
- iABORT in a non-IDLE state: IDLE next cycle, no oEND, counters cleared. iABORT has priority over iSTART and over the normal transition in the same cycle.
- Addresses are registered, with 1-cycle latency matching the synchronous ROM:
  - oWADDR <= iWBASE + iGROUP*GSTRIDE + iSTAGE, modulo 2^AW.
  - oTADDR <= iTBASE + iSTAGE, modulo 2^TW.
  - Both update every cycle regardless of state, using live iSTAGE/iGROUP.

Decomposition:
- Package bnn_seq_pkg: state encoding enum, parameter defaults, shared per-layer length constants:
  - conv2: 34/9/14/12/12
  - conv3: 44/6/12/9/9
  - fc: 56/1/-/-/1/tail 6
- One sub-module: bnn_seq_addr_gen, the registered ROM address arithmetic.

Test Plan:
- Conv2 config (pre 34, nrows 9, row 14, valid 12, last 12, tail 0) -> exactly 108 oSR_EN cycles; oEND 159 cycles after start (34+112+12+1); oROW ends at 8.
- Conv3 config (44, 6, 12, 9, 9) -> 54 oSR_EN cycles; oEND at cycle 44+60+9+1 = 114.
- FC config (pre 56, nrows 1, last 1, tail 6) -> single oSR_EN at cycle 57; oFINISH high 6 cycles; then oEND.
- iABORT at cycle 40 of conv2 run -> oBUSY low next cycle; no oEND; immediate new start behaves like a fresh run.
- pre 0, nrows 0, tail 0 -> DONE one cycle after start; oEND pulse; zero oSR_EN; start during busy ignored.
- iWBASE 96, iGROUP 2, iSTAGE 5 -> oWADDR=197 one cycle later; iWBASE 500, iGROUP 7 -> wraps mod 512; iRST_N low mid-run -> all outputs 0 immediately.
